// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order fetches to instruction memory, buffers
// responses in a circular fetch buffer and feeds the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_hazard_flag,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        proc2Imem_req,
  output logic [31:0] proc2Imem_addr,
  input  logic        Imem2proc_gnt,
  input  logic        Imem2proc_valid,
  input  logic [31:0] Imem2proc_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
);

  localparam int unsigned AW  = $clog2(FBUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(FBUF_DEPTH);

  logic [31:0]           fetch_pc;
  logic [31:0]           buf_pc   [FBUF_DEPTH];
  logic [31:0]           buf_inst [FBUF_DEPTH];
  logic [FBUF_DEPTH-1:0] buf_filled;

  ptr_t alloc_ptr;
  ptr_t fill_ptr;
  ptr_t head_ptr;
  ptr_t drop_cnt;
  ptr_t alloc_cnt;
  ptr_t pend_cnt;
  ptr_t owed_total;

  logic [AW:0]   occupancy_hi;
  logic [AW+1:0] occupancy;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] head_idx;

  logic grant;
  logic fill_en;
  logic drop_en;
  logic pop_en;
  logic head_filled;
  logic resp_in_flush;

  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign head_idx  = head_ptr[AW-1:0];

  assign alloc_cnt    = alloc_ptr - head_ptr;
  assign pend_cnt     = alloc_ptr - fill_ptr;
  assign owed_total   = pend_cnt + drop_cnt;
  assign occupancy_hi = '0;
  assign occupancy    = {1'b0, alloc_cnt} + {1'b0, drop_cnt} + {1'b0, occupancy_hi};

  assign proc2Imem_req  = !rst && !ex_take_branch && (occupancy < {1'b0, DEPTH_P});
  assign proc2Imem_addr = fetch_pc;

  assign grant         = proc2Imem_req && Imem2proc_gnt;
  assign drop_en       = Imem2proc_valid && (drop_cnt != '0);
  assign fill_en       = Imem2proc_valid && !ex_take_branch && (drop_cnt == '0) && (pend_cnt != '0);
  assign head_filled   = (alloc_cnt != '0) && buf_filled[head_idx];
  assign pop_en        = !ex_take_branch && !id_hazard_flag && head_filled;
  // A response landing in the redirect cycle pays off one owed response.
  assign resp_in_flush = Imem2proc_valid && (owed_total != '0);

  always_ff @(posedge clk) begin
    if (grant) begin
      buf_pc[alloc_idx] <= fetch_pc;
    end
    if (fill_en) begin
      buf_inst[fill_idx] <= Imem2proc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      drop_cnt   <= '0;
      buf_filled <= '0;
    end else if (ex_take_branch) begin
      fetch_pc   <= ex_target_pc & ~32'h3;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      buf_filled <= '0;
      drop_cnt   <= owed_total - ptr_t'(resp_in_flush);
    end else begin
      if (grant) begin
        alloc_ptr             <= alloc_ptr + ptr_t'(1);
        fetch_pc              <= fetch_pc + 32'd4;
        buf_filled[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        fill_ptr             <= fill_ptr + ptr_t'(1);
        buf_filled[fill_idx] <= 1'b1;
      end
      if (pop_en) begin
        head_ptr             <= head_ptr + ptr_t'(1);
        buf_filled[head_idx] <= 1'b0;
      end
      if (drop_en) begin
        drop_cnt <= drop_cnt - ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_IR         <= NOP;
      if_id_PC         <= '0;
      if_id_valid_inst <= 1'b0;
    end else if (ex_take_branch) begin
      if_id_IR         <= NOP;
      if_id_valid_inst <= 1'b0;
    end else if (id_hazard_flag) begin
      if_id_IR         <= if_id_IR;
      if_id_PC         <= if_id_PC;
      if_id_valid_inst <= if_id_valid_inst;
    end else if (head_filled) begin
      if_id_IR         <= buf_inst[head_idx];
      if_id_PC         <= buf_pc[head_idx];
      if_id_valid_inst <= 1'b1;
    end else begin
      if_id_IR         <= NOP;
      if_id_valid_inst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue-based memory and fetch-stream reference model,
// directed phases plus a randomized latency/stall/redirect phase.
module tb_if_stage;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        id_hazard_flag;
  logic        ex_take_branch;
  logic [31:0] ex_target_pc;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_gnt;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;

  if_stage #(
    .RESET_PC  (RST_PC),
    .FBUF_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_hazard_flag  (id_hazard_flag),
    .ex_take_branch  (ex_take_branch),
    .ex_target_pc    (ex_target_pc),
    .proc2Imem_req   (proc2Imem_req),
    .proc2Imem_addr  (proc2Imem_addr),
    .Imem2proc_gnt   (Imem2proc_gnt),
    .Imem2proc_valid (Imem2proc_valid),
    .Imem2proc_data  (Imem2proc_data),
    .if_id_IR        (if_id_IR),
    .if_id_PC        (if_id_PC),
    .if_id_valid_inst(if_id_valid_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Live fetches on the current path, oldest first; 'have' marks a returned word.
  typedef struct { logic [31:0] pc; bit have; } ent_t;
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;

  ent_t        live[$];
  mreq_t       mq[$];
  int unsigned owed;
  int unsigned cyc;
  int unsigned lat;
  int unsigned gnt_pct;
  int unsigned spur_pct;
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned n_fail;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_idpc;
  logic        m_valid;
  bit          model_known;
  bit          force_stale;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic hz, input logic br, input logic [31:0] tgt);
    bit          from_q;
    bit          exp_req;
    bit          head_ready;
    bit          filled_one;
    int unsigned unfilled;

    rst            = r;
    id_hazard_flag = hz;
    ex_take_branch = br;
    ex_target_pc   = tgt;
    Imem2proc_gnt  = ($urandom_range(99) < gnt_pct);
    from_q         = 1'b0;
    if (force_stale) begin
      Imem2proc_valid = 1'b1;
      Imem2proc_data  = $urandom;
      force_stale     = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      Imem2proc_valid = 1'b1;
      Imem2proc_data  = mem_word(mq[0].addr);
      from_q          = 1'b1;
    end else if (mq.size() == 0 && $urandom_range(99) < spur_pct) begin
      Imem2proc_valid = 1'b1;
      Imem2proc_data  = $urandom;
    end else begin
      Imem2proc_valid = 1'b0;
      Imem2proc_data  = $urandom;
    end
    #2;

    exp_req = !r && !br && ((live.size() + owed) < DEPTH);
    if (model_known) begin
      chk("req", {31'b0, proc2Imem_req}, {31'b0, exp_req});
      chk("addr", proc2Imem_addr, m_pc);
    end

    if (from_q) void'(mq.pop_front());
    if (proc2Imem_req && Imem2proc_gnt)
      mq.push_back('{addr: proc2Imem_addr, due: cyc + lat});

    if (r) begin
      live.delete();
      owed    = 0;
      m_pc    = RST_PC;
      m_ir    = NOP;
      m_idpc  = '0;
      m_valid = 1'b0;
    end else if (br) begin
      unfilled = 0;
      foreach (live[i]) if (!live[i].have) unfilled++;
      owed = unfilled + owed;
      if (Imem2proc_valid && owed > 0) owed--;
      live.delete();
      m_pc    = tgt & ~32'h3;
      m_ir    = NOP;
      m_valid = 1'b0;
    end else begin
      head_ready = (live.size() > 0) && live[0].have;
      if (Imem2proc_valid) begin
        if (owed > 0) owed--;
        else begin
          filled_one = 1'b0;
          foreach (live[i]) begin
            if (!filled_one && !live[i].have) begin
              live[i].have = 1'b1;
              filled_one   = 1'b1;
            end
          end
        end
      end
      if (!hz) begin
        if (head_ready) begin
          m_idpc  = live[0].pc;
          m_ir    = mem_word(live[0].pc);
          m_valid = 1'b1;
          void'(live.pop_front());
        end else begin
          m_ir    = NOP;
          m_valid = 1'b0;
        end
      end
      if (exp_req && Imem2proc_gnt) begin
        live.push_back('{pc: m_pc, have: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("if_id_IR", if_id_IR, m_ir);
    chk("if_id_PC", if_id_PC, m_idpc);
    chk("if_id_valid", {31'b0, if_id_valid_inst}, {31'b0, m_valid});
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    cyc = 0; owed = 0; model_known = 1'b0; force_stale = 1'b0;
    m_pc = RST_PC; m_ir = NOP; m_idpc = '0; m_valid = 1'b0;
    rst = 1'b1; id_hazard_flag = 1'b0; ex_take_branch = 1'b0; ex_target_pc = '0;
    Imem2proc_gnt = 1'b0; Imem2proc_valid = 1'b0; Imem2proc_data = '0;
    lat = 1; gnt_pct = 100; spur_pct = 0;

    // Reset, then 1-cycle memory streaming
    cycle(1'b1, 1'b0, 1'b0, '0);
    model_known = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, '0);
    mq.delete();
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '0);

    // Decode stall for 6 cycles, then release
    repeat (6) cycle(1'b0, 1'b1, 1'b0, '0);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, '0);

    // Redirect to an unaligned target with requests outstanding
    lat = 2;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, '0);

    // Redirect coincident with a response and a decode stall
    lat = 1;
    repeat (4) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, '0);

    // 3-cycle memory, random grants, stalls, redirects and spurious responses
    lat = 3; gnt_pct = 60; spur_pct = 15;
    repeat (400) cycle(1'b0, ($urandom_range(99) < 25), ($urandom_range(99) < 3), $urandom);

    // PC wrap past 0xFFFF_FFFC
    lat = 1; gnt_pct = 100; spur_pct = 0;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '0);

    // Reset mid-stream with fetches in flight, followed by a stale response
    lat = 3;
    repeat (5) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    mq.delete();
    force_stale = 1'b1;
    repeat (12) cycle(1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
